// File: rtl/la_pkg.sv
// Shared types and constants for the logic analyzer capture path.
package la_pkg;

  localparam int unsigned LA_ENTRIES = 384;
  localparam int unsigned LA_AW      = 9;

  // Bit positions within the trig_cfg host register
  localparam int unsigned TRIG_CFG_RUN_BIT      = 0;
  localparam int unsigned TRIG_CFG_CAP_DONE_BIT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StArmed,
    StPost,
    StDone
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer for the circular channel RAMs: pre-trigger fill, arm, post count, freeze.
// Define CAP_TRIG_ADDR_EN to add the registered trig_addr output.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned ENTRIES = LA_ENTRIES,
  parameter int unsigned AW      = LA_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          run,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  input  logic          clr_cap_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          capture_done
`ifdef CAP_TRIG_ADDR_EN
  ,
  output logic [AW-1:0] trig_addr
`endif
);

  localparam logic [AW-1:0] LastAddr = AW'(ENTRIES - 1);
  localparam logic [AW:0]   EntriesW = (AW + 1)'(ENTRIES);

  cap_state_t    state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d, post_inc;
  logic [AW:0]   smpl_cnt_q, smpl_cnt_d, smpl_inc;
  logic          capture_done_q, capture_done_d;
  logic [AW-1:0] tp;

  assign tp       = (trig_pos > LastAddr) ? LastAddr : trig_pos;
  assign smpl_inc = (smpl_cnt_q >= EntriesW) ? EntriesW : smpl_cnt_q + (AW + 1)'(1);
  assign post_inc = post_cnt_q + AW'(1);

  assign we           = wrt_smpl & (state_q inside {StPre, StArmed, StPost});
  assign armed        = (state_q == StArmed);
  assign waddr        = waddr_q;
  assign capture_done = capture_done_q;

  always_comb begin
    waddr_d = waddr_q;
    if (we) begin
      waddr_d = (waddr_q == LastAddr) ? '0 : waddr_q + AW'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    smpl_cnt_d     = smpl_cnt_q;
    post_cnt_d     = post_cnt_q;
    capture_done_d = capture_done_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StPre;
          smpl_cnt_d = '0;
          post_cnt_d = '0;
        end
      end
      StPre: begin
        if (!run) begin
          state_d = StIdle;
        end else if (we) begin
          smpl_cnt_d = smpl_inc;
          if (smpl_inc >= EntriesW - {1'b0, tp}) state_d = StArmed;
        end
      end
      StArmed: begin
        if (!run) begin
          state_d = StIdle;
        end else if (triggered) begin
          if (tp == '0) begin
            state_d        = StDone;
            capture_done_d = 1'b1;
          end else begin
            state_d = StPost;
          end
        end
      end
      StPost: begin
        if (!run) begin
          state_d = StIdle;
        end else if (we) begin
          post_cnt_d = post_inc;
          if (post_inc == tp) begin
            state_d        = StDone;
            capture_done_d = 1'b1;
          end
        end
      end
      StDone: begin
        // Buffer stays frozen until the host acknowledges; run is ignored here
        if (clr_cap_done) begin
          state_d        = StIdle;
          capture_done_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      waddr_q        <= '0;
      smpl_cnt_q     <= '0;
      post_cnt_q     <= '0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      waddr_q        <= waddr_d;
      smpl_cnt_q     <= smpl_cnt_d;
      post_cnt_q     <= post_cnt_d;
      capture_done_q <= capture_done_d;
    end
  end

`ifdef CAP_TRIG_ADDR_EN
  logic [AW-1:0] trig_addr_q;
  logic          trig_accept;

  assign trig_accept = (state_q == StArmed) & run & triggered;
  assign trig_addr   = trig_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_addr_q <= '0;
    end else if (trig_accept) begin
      trig_addr_q <= waddr_q;
    end
  end
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl; write address stream checked through a scoreboard.
module tb_capture_ctrl;
  import la_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wrt_smpl;
  logic       run;
  logic       triggered;
  logic [8:0] trig_pos;
  logic       clr_cap_done;
  logic       we;
  logic [8:0] waddr;
  logic       armed;
  logic       capture_done;
`ifdef CAP_TRIG_ADDR_EN
  logic [8:0] trig_addr;
`endif

  capture_ctrl #(
    .ENTRIES(384),
    .AW     (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wrt_smpl    (wrt_smpl),
    .run         (run),
    .triggered   (triggered),
    .trig_pos    (trig_pos),
    .clr_cap_done(clr_cap_done),
    .we          (we),
    .waddr       (waddr),
    .armed       (armed),
    .capture_done(capture_done)
`ifdef CAP_TRIG_ADDR_EN
    ,
    .trig_addr   (trig_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [8:0] addr;
  } smp_t;

  smp_t       exp_q[$];
  smp_t       obs_q[$];
  smp_t       bad_exp, bad_obs;
  logic [8:0] exp_addr;
  logic [8:0] prev_wa;
  logic       armed_seen;
  logic       wrap_seen;
  int         checks = 0;
  int         passes = 0;
  int         bad;

  // One strobe cycle; the expected we/address is queued alongside what the DUT showed.
  task automatic wr(input logic exp_we, input int gap);
    smp_t o, e;
    @(negedge clk);
    wrt_smpl = 1'b1;
    #1;
    o.we   = we;
    o.addr = waddr;
    e.we   = exp_we;
    e.addr = exp_addr;
    obs_q.push_back(o);
    exp_q.push_back(e);
    armed_seen = armed_seen | armed;
    if (we && prev_wa == 9'd383 && waddr == 9'd0) wrap_seen = 1'b1;
    if (we) prev_wa = waddr;
    if (exp_we) exp_addr = (exp_addr == 9'd383) ? 9'd0 : exp_addr + 9'd1;
    @(negedge clk);
    wrt_smpl = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain(output int nbad);
    smp_t o, e;
    nbad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        if (nbad == 0) begin
          bad_exp = e;
          bad_obs = o;
        end
        nbad++;
      end
    end
    if (exp_q.size() != obs_q.size()) nbad++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clear_done();
    @(negedge clk);
    run          = 1'b0;
    triggered    = 1'b0;
    clr_cap_done = 1'b1;
    @(negedge clk);
    clr_cap_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    run      = 1'b1;
    wrt_smpl = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (waddr !== 9'd0) $display("FAIL reset_waddr: got %0d want 0", waddr);
    else passes++;
    checks++;
    if ({we, armed, capture_done} !== 3'b000)
      $display("FAIL reset_flags: we/armed/done got %b want 000", {we, armed, capture_done});
    else passes++;
    rst_n    = 1'b1;
    run      = 1'b0;
    wrt_smpl = 1'b0;
    exp_addr = 9'd0;
    prev_wa  = 9'd0;
    // Strobe while idle must not write
    wr(1'b0, 1);
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL idle_no_write: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
  endtask

  task automatic test_pre_fill();
    @(negedge clk);
    trig_pos   = 9'd128;
    triggered  = 1'b1;
    run        = 1'b1;
    armed_seen = 1'b0;
    repeat (255) wr(1'b1, 3);
    checks++;
    if (armed_seen !== 1'b0) $display("FAIL pre_fill_early_arm: armed seen %b want 0", armed_seen);
    else passes++;
    wr(1'b1, 1);
    checks++;
    if (armed !== 1'b1) $display("FAIL pre_fill_armed: got %b want 1", armed);
    else passes++;
    @(negedge clk);
    checks++;
    if ({armed, capture_done} !== 2'b00)
      $display("FAIL pre_fill_post_entry: armed/done got %b want 00", {armed, capture_done});
    else passes++;
  endtask

  task automatic test_post_count();
    repeat (127) wr(1'b1, 3);
    checks++;
    if (capture_done !== 1'b0) $display("FAIL post_early_done: got %b want 0", capture_done);
    else passes++;
    wr(1'b1, 1);
    checks++;
    if (capture_done !== 1'b1) $display("FAIL post_done: got %b want 1", capture_done);
    else passes++;
    checks++;
    if (waddr !== 9'd0) $display("FAIL post_waddr: got %0d want 0", waddr);
    else passes++;
    repeat (50) wr(1'b0, 3);
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL fill_post_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    clear_done();
    checks++;
    if ({capture_done, armed} !== 2'b00)
      $display("FAIL clear_done: done/armed got %b want 00", {capture_done, armed});
    else passes++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    trig_pos  = 9'd128;
    triggered = 1'b0;
    run       = 1'b1;
    wrap_seen = 1'b0;
    repeat (500) wr(1'b1, 1);
    checks++;
    if ({wrap_seen, armed} !== 2'b11)
      $display("FAIL wrap_seen_armed: got %b want 11", {wrap_seen, armed});
    else passes++;
    triggered = 1'b1;
    @(negedge clk);
    triggered = 1'b0;
    repeat (127) wr(1'b1, 1);
    checks++;
    if (capture_done !== 1'b0) $display("FAIL wrap_early_done: got %b want 0", capture_done);
    else passes++;
    wr(1'b1, 1);
    checks++;
    if ({capture_done, waddr} !== {1'b1, 9'd244})
      $display("FAIL wrap_final: done %b waddr %0d want 1 244", capture_done, waddr);
    else passes++;
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL wrap_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    clear_done();
  endtask

  task automatic test_tp_zero();
    @(negedge clk);
    trig_pos  = 9'd0;
    triggered = 1'b1;
    run       = 1'b1;
    repeat (383) wr(1'b1, 1);
    checks++;
    if (armed !== 1'b0) $display("FAIL tp0_early_arm: got %b want 0", armed);
    else passes++;
    wr(1'b1, 1);
    checks++;
    if ({armed, capture_done} !== 2'b10)
      $display("FAIL tp0_armed: armed/done got %b want 10", {armed, capture_done});
    else passes++;
    @(negedge clk);
    checks++;
    if ({capture_done, armed, waddr} !== {2'b10, 9'd244})
      $display("FAIL tp0_done: done/armed %b waddr %0d want 10 244", {capture_done, armed}, waddr);
    else passes++;
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL tp0_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    clear_done();
  endtask

  task automatic test_tp_clamp();
    @(negedge clk);
    trig_pos  = 9'd400;
    triggered = 1'b1;
    run       = 1'b1;
    wr(1'b1, 1);
    checks++;
    if (armed !== 1'b1) $display("FAIL clamp_armed: got %b want 1", armed);
    else passes++;
    @(negedge clk);
    repeat (382) wr(1'b1, 1);
    checks++;
    if (capture_done !== 1'b0) $display("FAIL clamp_early_done: got %b want 0", capture_done);
    else passes++;
    wr(1'b1, 1);
    checks++;
    if ({capture_done, waddr} !== {1'b1, 9'd244})
      $display("FAIL clamp_done: done %b waddr %0d want 1 244", capture_done, waddr);
    else passes++;
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL clamp_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    clear_done();
  endtask

  task automatic test_abort();
    smp_t o, e;
    @(negedge clk);
    trig_pos  = 9'd128;
    triggered = 1'b1;
    run       = 1'b1;
    repeat (256) wr(1'b1, 1);
    @(negedge clk);
    repeat (10) wr(1'b1, 1);
    // Drop run with a strobe in the same cycle; that write still lands
    @(negedge clk);
    run      = 1'b0;
    wrt_smpl = 1'b1;
    #1;
    o.we   = we;
    o.addr = waddr;
    e.we   = 1'b1;
    e.addr = exp_addr;
    obs_q.push_back(o);
    exp_q.push_back(e);
    exp_addr = (exp_addr == 9'd383) ? 9'd0 : exp_addr + 9'd1;
    @(negedge clk);
    #1;
    checks++;
    if ({we, armed, capture_done, waddr} !== {3'b000, 9'd127})
      $display("FAIL abort_idle: we/armed/done %b waddr %0d want 000 127",
               {we, armed, capture_done}, waddr);
    else passes++;
    wrt_smpl  = 1'b0;
    triggered = 1'b0;
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL abort_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
  endtask

  task automatic test_reset_mid_pre();
    @(negedge clk);
    trig_pos = 9'd128;
    run      = 1'b1;
    repeat (20) wr(1'b1, 1);
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL midpre_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({waddr, armed} !== {9'd0, 1'b0})
      $display("FAIL midpre_reset: waddr %0d armed %b want 0 0", waddr, armed);
    else passes++;
    rst_n    = 1'b1;
    run      = 1'b0;
    exp_addr = 9'd0;
  endtask

`ifdef CAP_TRIG_ADDR_EN
  task automatic test_trig_addr();
    checks++;
    if (trig_addr !== 9'd0) $display("FAIL trig_addr_reset: got %0d want 0", trig_addr);
    else passes++;
    @(negedge clk);
    trig_pos  = 9'd128;
    triggered = 1'b0;
    run       = 1'b1;
    repeat (461) wr(1'b1, 1);
    checks++;
    if ({armed, waddr} !== {1'b1, 9'd77})
      $display("FAIL trig_addr_pre: armed %b waddr %0d want 1 77", armed, waddr);
    else passes++;
    triggered = 1'b1;
    @(negedge clk);
    triggered = 1'b0;
    checks++;
    if (trig_addr !== 9'd77) $display("FAIL trig_addr_load: got %0d want 77", trig_addr);
    else passes++;
    repeat (128) wr(1'b1, 1);
    repeat (5) wr(1'b0, 1);
    checks++;
    if ({capture_done, trig_addr} !== {1'b1, 9'd77})
      $display("FAIL trig_addr_done: done %b trig_addr %0d want 1 77", capture_done, trig_addr);
    else passes++;
    drain(bad);
    checks++;
    if (bad !== 0) $display("FAIL trig_addr_stream: %0d bad, got %h want %h", bad, bad_obs, bad_exp);
    else passes++;
    clear_done();
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    wrt_smpl     = 1'b0;
    run          = 1'b0;
    triggered    = 1'b0;
    trig_pos     = 9'd128;
    clr_cap_done = 1'b0;
    exp_addr     = 9'd0;
    prev_wa      = 9'd0;
    armed_seen   = 1'b0;
    wrap_seen    = 1'b0;
    test_reset();
    test_pre_fill();
    test_post_count();
    test_wrap();
    test_tp_zero();
    test_tp_clamp();
    test_abort();
    test_reset_mid_pre();
`ifdef CAP_TRIG_ADDR_EN
    test_trig_addr();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
